// File: rtl/pulse_param_loader.sv
// Parses SYNC + 18-byte payload + checksum frames from the UART receiver and commits the
// parameter set atomically at a period boundary. Optional range check: PULSE_PARAM_RANGECHK_EN.
module pulse_param_loader #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        period_start,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [7:0]  nut_w,
  output logic [15:0] nut_d,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_off,
  output logic        bl,
  output logic        update,
  output logic        pending,
  output logic        frame_ok,
  output logic        frame_err
);

  localparam int PAYLOAD_LEN = 18;
  // Parameter set packed in payload order; only bit 0 of the final byte is kept.
  localparam int PW = 137;
  localparam logic [4:0]    LAST_IDX    = 5'(PAYLOAD_LEN - 1);
  localparam logic [15:0]   IDLE_LAST   = 16'(TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] PRM_DEFAULT = {32'd20000, 16'd30, 16'd200, 16'd60, 8'd0,
                                           16'd0, 8'd1, 8'd50, 16'd100, 1'b1};

  typedef enum logic [1:0] {ST_HUNT = 2'd0, ST_PAYLOAD = 2'd1, ST_CHECK = 2'd2} state_t;

  state_t        state_r, state_nxt_s;
  logic [4:0]    idx_r;
  logic [7:0]    sum_r;
  logic [15:0]   idle_r;
  logic [PW-1:0] stg_r, shd_r, prm_r;
  logic          pending_r, update_r, frame_ok_r, frame_err_r;
  logic          start_s, store_s, pass_s, fail_s, timeout_s;
  logic          accept_s, reject_s, commit_s;

  assign timeout_s = (state_r != ST_HUNT) && !rx_valid && (idle_r == IDLE_LAST);
  assign commit_s  = pending_r && period_start;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_HUNT;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HUNT: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_nxt_s = ST_PAYLOAD;
        else                                    state_nxt_s = ST_HUNT;
      end
      ST_PAYLOAD: begin
        if (timeout_s)                           state_nxt_s = ST_HUNT;
        else if (rx_valid && (idx_r == LAST_IDX)) state_nxt_s = ST_CHECK;
        else                                     state_nxt_s = ST_PAYLOAD;
      end
      ST_CHECK: begin
        if (timeout_s || rx_valid) state_nxt_s = ST_HUNT;
        else                       state_nxt_s = ST_CHECK;
      end
      default: state_nxt_s = ST_HUNT;
    endcase
  end

  // FSM output decode: per-byte actions
  always_comb begin
    start_s = 1'b0;
    store_s = 1'b0;
    pass_s  = 1'b0;
    fail_s  = 1'b0;
    case (state_r)
      ST_HUNT:    start_s = rx_valid && (rx_data == SYNC_BYTE);
      ST_PAYLOAD: store_s = rx_valid;
      ST_CHECK: begin
        pass_s = rx_valid && (rx_data == sum_r);
        fail_s = rx_valid && (rx_data != sum_r);
      end
      default: begin
        start_s = 1'b0;
        store_s = 1'b0;
      end
    endcase
  end

  // Byte index, running checksum, idle counter and staging register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r  <= 5'd0;
      sum_r  <= 8'd0;
      idle_r <= 16'd0;
      stg_r  <= PRM_DEFAULT;
    end else begin
      if (start_s) begin
        idx_r <= 5'd0;
        sum_r <= 8'd0;
      end else if (store_s) begin
        idx_r <= idx_r + 5'd1;
        sum_r <= sum_r + rx_data;
      end
      if ((state_r == ST_HUNT) || rx_valid) idle_r <= 16'd0;
      else if (idle_r != 16'hFFFF)          idle_r <= idle_r + 16'd1;
      if (store_s) begin
        for (int i = 0; i < PAYLOAD_LEN - 1; i++) begin
          if (idx_r == 5'(i)) stg_r[PW-1-8*i -: 8] <= rx_data;
        end
        if (idx_r == LAST_IDX) stg_r[0] <= rx_data[0];
      end
    end
  end

`ifdef PULSE_PARAM_RANGECHK_EN
  function automatic logic range_ok(input logic [31:0] v_per, input logic [15:0] v_p1,
                                    input logic [15:0] v_del, input logic [15:0] v_p2,
                                    input logic [7:0] v_pbl, input logic [15:0] v_pbo);
    logic [32:0] span;
    span = {17'd0, v_p1} + {17'd0, v_del} + {17'd0, v_p2} + {17'd0, v_del};
    return (span < {1'b0, v_per}) && (v_pbo > {8'd0, v_pbl});
  endfunction

  logic chk_r, err_d_r, rng_ok_s;

  // Staging is stable for the cycle after the checksum byte, so the check runs from it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_r   <= 1'b0;
      err_d_r <= 1'b0;
    end else begin
      chk_r   <= pass_s;
      err_d_r <= fail_s || timeout_s;
    end
  end

  assign rng_ok_s = range_ok(stg_r[136:105], stg_r[104:89], stg_r[88:73], stg_r[72:57],
                             stg_r[24:17], stg_r[16:1]);
  assign accept_s = chk_r && rng_ok_s;
  assign reject_s = err_d_r || (chk_r && !rng_ok_s);
`else
  assign accept_s = pass_s;
  assign reject_s = fail_s || timeout_s;
`endif

  // Shadow capture, boundary commit and status strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shd_r       <= PRM_DEFAULT;
      prm_r       <= PRM_DEFAULT;
      pending_r   <= 1'b0;
      update_r    <= 1'b0;
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (accept_s) shd_r <= stg_r;
      if (commit_s) prm_r <= shd_r;
      pending_r   <= accept_s || (pending_r && !period_start);
      update_r    <= commit_s;
      frame_ok_r  <= accept_s;
      frame_err_r <= reject_s;
    end
  end

  assign per       = prm_r[136:105];
  assign p1wid     = prm_r[104:89];
  assign del       = prm_r[88:73];
  assign p2wid     = prm_r[72:57];
  assign nut_w     = prm_r[56:49];
  assign nut_d     = prm_r[48:33];
  assign cp        = prm_r[32:25];
  assign p_bl      = prm_r[24:17];
  assign p_bl_off  = prm_r[16:1];
  assign bl        = prm_r[0];
  assign update    = update_r;
  assign pending   = pending_r;
  assign frame_ok  = frame_ok_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Directed bench for pulse_param_loader: framing, checksum, timeout and boundary commit.
module tb_pulse_param_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        period_start = 1'b0;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
  logic [7:0]  nut_w, cp, p_bl;
  logic        bl, update, pending, frame_ok, frame_err;

  int vectors = 0;
  int miscompares = 0;
  int ok_cnt = 0, err_cnt = 0, upd_cnt = 0;
  int n, o0, e0, u0;

`ifdef PULSE_PARAM_RANGECHK_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  always #10 clk = ~clk;

  pulse_param_loader dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .period_start(period_start), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
    .nut_w(nut_w), .nut_d(nut_d), .cp(cp), .p_bl(p_bl), .p_bl_off(p_bl_off), .bl(bl),
    .update(update), .pending(pending), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always @(posedge clk) begin
    if (frame_ok)  ok_cnt  <= ok_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (update)    upd_cnt <= upd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_prm(input string tag, input logic [31:0] e_per, input logic [15:0] e_p1,
                         input logic [15:0] e_del, input logic [15:0] e_p2, input logic [7:0] e_nw,
                         input logic [15:0] e_nd, input logic [7:0] e_cp, input logic [7:0] e_pbl,
                         input logic [15:0] e_pbo, input logic e_bl);
    chk({tag, ".per"}, per, e_per);
    chk({tag, ".p1wid"}, 32'(p1wid), 32'(e_p1));
    chk({tag, ".del"}, 32'(del), 32'(e_del));
    chk({tag, ".p2wid"}, 32'(p2wid), 32'(e_p2));
    chk({tag, ".nut_w"}, 32'(nut_w), 32'(e_nw));
    chk({tag, ".nut_d"}, 32'(nut_d), 32'(e_nd));
    chk({tag, ".cp"}, 32'(cp), 32'(e_cp));
    chk({tag, ".p_bl"}, 32'(p_bl), 32'(e_pbl));
    chk({tag, ".p_bl_off"}, 32'(p_bl_off), 32'(e_pbo));
    chk({tag, ".bl"}, 32'(bl), 32'(e_bl));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_ps();
    @(negedge clk);
    period_start = 1'b1;
    @(negedge clk);
    period_start = 1'b0;
  endtask

  // Checksum byte is driven together with period_start when with_ps is set.
  task automatic send_frame(input logic [31:0] v_per, input logic [15:0] v_p1, input logic [15:0] v_del,
                            input logic [15:0] v_p2, input logic [7:0] v_nw, input logic [15:0] v_nd,
                            input logic [7:0] v_cp, input logic [7:0] v_pbl, input logic [15:0] v_pbo,
                            input logic [7:0] v_bl, input logic [7:0] cks_adj, input logic with_ps);
    logic [143:0] pl;
    logic [7:0]   s;
    logic [7:0]   b;
    pl = {v_per, v_p1, v_del, v_p2, v_nw, v_nd, v_cp, v_pbl, v_pbo, v_bl};
    s  = 8'd0;
    send_byte(8'hA5);
    for (int i = 0; i < 18; i++) begin
      b = pl[143-8*i -: 8];
      s = s + b;
      send_byte(b);
    end
    s = s + cks_adj;
    @(negedge clk);
    rx_valid     = 1'b1;
    rx_data      = s;
    period_start = with_ps;
    @(negedge clk);
    rx_valid     = 1'b0;
    period_start = 1'b0;
  endtask

  initial begin
    // Reset and idle defaults
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_prm("rst", 32'd20000, 16'd30, 16'd200, 16'd60, 8'd0, 16'd0, 8'd1, 8'd50, 16'd100, 1'b1);
    chk("rst.update", 32'(update), 32'd0);
    chk("rst.pending", 32'(pending), 32'd0);
    chk("rst.frame_ok", 32'(frame_ok), 32'd0);
    chk("rst.frame_err", 32'(frame_err), 32'd0);
    pulse_ps();
    repeat (2) @(negedge clk);
    chk("idle.ps_no_update", 32'(upd_cnt), 32'd0);
    chk("idle.per", per, 32'd20000);
    chk("idle.ok_cnt", 32'(ok_cnt), 32'd0);
    chk("idle.err_cnt", 32'(err_cnt), 32'd0);

    // Frame A, commit 100 cycles later; bl byte 0xFE gives bl=0
    send_frame(32'd40000, 16'd50, 16'd300, 16'd100, 8'd7, 16'd500, 8'd3, 8'd40, 16'd120, 8'hFE, 8'd0, 1'b0);
    repeat (LAT) @(negedge clk);
    chk("A.frame_ok", 32'(frame_ok), 32'd1);
    chk("A.pending", 32'(pending), 32'd1);
    @(negedge clk);
    chk("A.frame_ok_1cyc", 32'(frame_ok), 32'd0);
    repeat (100) @(negedge clk);
    chk("A.pending_hold", 32'(pending), 32'd1);
    @(negedge clk);
    period_start = 1'b1;
    chk("A.per_before", per, 32'd20000);
    @(negedge clk);
    period_start = 1'b0;
    chk("A.update", 32'(update), 32'd1);
    chk("A.pending_clr", 32'(pending), 32'd0);
    chk_prm("A", 32'd40000, 16'd50, 16'd300, 16'd100, 8'd7, 16'd500, 8'd3, 8'd40, 16'd120, 1'b0);
    @(negedge clk);
    chk("A.update_1cyc", 32'(update), 32'd0);

    // Frame B with checksum+1
    o0 = ok_cnt;
    e0 = err_cnt;
    send_frame(32'd12345, 16'd11, 16'd22, 16'd33, 8'd1, 16'd2, 8'd5, 8'd6, 16'd70, 8'd1, 8'd1, 1'b0);
    repeat (4) @(negedge clk);
    chk("B.err_cnt", 32'(err_cnt), 32'(e0 + 1));
    chk("B.ok_cnt", 32'(ok_cnt), 32'(o0));
    chk("B.pending", 32'(pending), 32'd0);
    for (int k = 0; k < 5; k++) pulse_ps();
    repeat (2) @(negedge clk);
    chk("B.upd_cnt", 32'(upd_cnt), 32'd1);
    chk_prm("B", 32'd40000, 16'd50, 16'd300, 16'd100, 8'd7, 16'd500, 8'd3, 8'd40, 16'd120, 1'b0);

    // Truncated frame: timeout after 50000 idle cycles
    e0 = err_cnt;
    send_byte(8'hA5);
    for (int k = 0; k < 10; k++) send_byte(8'(k + 1));
    n = 0;
    while (!frame_err && n < 50100) begin
      @(negedge clk);
      n++;
    end
    chk("TO.cycles", 32'(n), 32'd50000);
    repeat (2) @(negedge clk);
    chk("TO.err_cnt", 32'(err_cnt), 32'(e0 + 1));
    o0 = ok_cnt;
    send_frame(32'd25000, 16'd40, 16'd250, 16'd80, 8'd0, 16'd0, 8'd1, 8'd50, 16'd100, 8'd1, 8'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("C.ok_cnt", 32'(ok_cnt), 32'(o0 + 1));
    chk("C.pending", 32'(pending), 32'd1);
    pulse_ps();
    chk("C.per", per, 32'd25000);

    // Two frames before a boundary; E carries 0xA5 inside the payload
    o0 = ok_cnt;
    send_frame(32'd30000, 16'd30, 16'd200, 16'd60, 8'd0, 16'd0, 8'd1, 8'd50, 16'd100, 8'd1, 8'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("D.pending", 32'(pending), 32'd1);
    send_frame(32'd35000, 16'd60, 16'd400, 16'd120, 8'd5, 16'd1000, 8'd4, 8'hA5, 16'h0100, 8'd1, 8'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("E.pending", 32'(pending), 32'd1);
    chk("E.ok_cnt", 32'(ok_cnt), 32'(o0 + 2));
    u0 = upd_cnt;
    pulse_ps();
    chk_prm("E", 32'd35000, 16'd60, 16'd400, 16'd120, 8'd5, 16'd1000, 8'd4, 8'hA5, 16'h0100, 1'b1);
    chk("E.pending_clr", 32'(pending), 32'd0);
    pulse_ps();
    repeat (2) @(negedge clk);
    chk("E.single_commit", 32'(upd_cnt), 32'(u0 + 1));

    // Checksum acceptance coincides with a boundary: old shadow commits, new frame waits
    send_frame(32'd11111, 16'd30, 16'd200, 16'd60, 8'd0, 16'd0, 8'd1, 8'd50, 16'd100, 8'd1, 8'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("F.pending", 32'(pending), 32'd1);
    send_frame(32'd22222, 16'd30, 16'd200, 16'd60, 8'd0, 16'd0, 8'd2, 8'd50, 16'd100, 8'd1, 8'd0, 1'b1);
    chk("G.update", 32'(update), 32'd1);
    chk("G.per_old", per, 32'd11111);
    repeat (LAT + 1) @(negedge clk);
    chk("G.pending", 32'(pending), 32'd1);
    pulse_ps();
    chk("G.per", per, 32'd22222);
    chk("G.cp", 32'(cp), 32'd2);

`ifdef PULSE_PARAM_RANGECHK_EN
    // Range violation: 30+200+60+200 = 490 >= 400
    o0 = ok_cnt;
    e0 = err_cnt;
    send_frame(32'd400, 16'd30, 16'd200, 16'd60, 8'd0, 16'd0, 8'd1, 8'd50, 16'd100, 8'd1, 8'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("R.err_cnt", 32'(err_cnt), 32'(e0 + 1));
    chk("R.ok_cnt", 32'(ok_cnt), 32'(o0));
    chk("R.pending", 32'(pending), 32'd0);
    pulse_ps();
    chk("R.per", per, 32'd22222);
`endif

    // Reset while a frame is pending
    send_frame(32'd33333, 16'd30, 16'd200, 16'd60, 8'd0, 16'd0, 8'd1, 8'd50, 16'd100, 8'd1, 8'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("H.pending", 32'(pending), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("H.rst_pending", 32'(pending), 32'd0);
    chk("H.rst_per", per, 32'd20000);
    reset = 1'b1;
    pulse_ps();
    chk("H.per_after", per, 32'd20000);
    chk("H.update", 32'(update), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
